inst_encoder: RTL



---
 rtl/inst_encoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_encoder                                                  |
// | Brief    : Packs instruction fields into 16-bit words and loads them     |
// |            into instruction memory at consecutive addresses.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inst_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_a,
    input  logic [3:0]        in_b,
    input  logic [3:0]        in_c,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [3:0]        OP_COM    = 4'd4;
    localparam logic [3:0]        OP_MAX    = 4'd10;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;

    logic              w_hs;
    logic              w_legal;
    logic              w_at_end;
    logic [15:0]       w_enc;

    assign w_hs     = in_valid && (state_q == ST_ACCEPT);
    assign w_legal  = (in_op <= OP_MAX);
    assign w_at_end = (addr_q == LAST_ADDR);
    // COM has no third operand; its C field is forced to zero.
    assign w_enc    = {in_op, in_a, in_b, (in_op == OP_COM) ? 4'h0 : in_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_ACCEPT;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACCEPT: begin
                    if (w_hs) begin
                        if (w_legal) begin
                            state_d = ST_WRITE;
                        end else if (in_last) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_WRITE:  state_d = (last_q || w_at_end) ? ST_FINISH : ST_ACCEPT;
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == ST_ACCEPT);
        imem_we  = (state_q == ST_WRITE);
        busy     = (state_q != ST_IDLE);
    end

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        done_d  = done_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        if (start) begin
            addr_d  = '0;
            count_d = '0;
            word_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b0;
            ill_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (state_q == ST_ACCEPT && w_hs) begin
                if (w_legal) begin
                    word_d = w_enc;
                    last_d = in_last;
                end else begin
                    ill_d = 1'b1;
                end
            end
            // The address saturates at the last word so it can never wrap.
            if (state_q == ST_WRITE) begin
                count_d = count_q + CNT_ONE;
                if (!w_at_end) begin
                    addr_d = addr_q + ADDR_ONE;
                end else if (!last_q) begin
                    ovf_d = 1'b1;
                end
            end
            if (state_d == ST_FINISH) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign imem_addr    = addr_q;
    assign imem_wdata   = word_q;
    assign count        = count_q;
    assign done         = done_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;

endmodule
`default_nettype wire
